// File: rtl/line_feeder_y_pkg.sv
// Shared constants, FSM state type and small helpers for the vertical line feeder.
package line_feeder_y_pkg;

  localparam int NTAP    = 5;
  localparam int MAX_DEC = 5;
  localparam int PIX_W   = 8;

  typedef enum logic {
    FILL = 1'b0,
    READ = 1'b1
  } state_t;

  // Decimation factor: 0 behaves as 1, anything above MAX_DEC saturates.
  function automatic logic [2:0] clamp_dec(input logic [2:0] d);
    if (d == 3'd0) return 3'd1;
    if (d > 3'(MAX_DEC)) return 3'(MAX_DEC);
    return d;
  endfunction

  // Line width: 0 or anything wider than the buffers means full width.
  function automatic logic [6:0] clamp_width(input logic [6:0] w, input logic [6:0] max_w);
    if (w == 7'd0 || w > max_w) return max_w;
    return w;
  endfunction

  // Row buffer index k rows behind row (modulo NTAP), k in 1..NTAP.
  function automatic logic [2:0] row_back(input logic [2:0] row, input logic [2:0] k);
    logic [3:0] t;
    t = {1'b0, row} + 4'(NTAP) - {1'b0, k};
    if (t >= 4'(NTAP)) t = t - 4'(NTAP);
    return t[2:0];
  endfunction

endpackage

// File: rtl/line_ram.sv
// One line buffer: single write port, single synchronous read port.
// Contents are never cleared; only the addressed word is read on re.
module line_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write and registered read; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_feeder_y.sv
// Vertical line feeder: buffers filtered lines in five circular row buffers
// and, every D lines, streams out a column of the D newest lines.
// Optional feature macro: LINE_FEEDER_Y_ROW_CNT_EN adds the out_row counter.
//
// Input handshake: a pixel transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in FILL, and a pixel
// offered in a sof cycle is dropped.
module line_feeder_y
  import line_feeder_y_pkg::*;
#(
  parameter int MAX_W = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sof,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pix,
  input  logic [6:0] cfg_width,
  input  logic [2:0] cfg_dec,
  output logic       en_load,
  output logic [7:0] br1P,
  output logic [7:0] br2P,
  output logic [7:0] br3P,
  output logic [7:0] br4P,
  output logic [7:0] br5P,
`ifdef LINE_FEEDER_Y_ROW_CNT_EN
  output logic [7:0] out_row,
`endif
  output logic       dbg_state
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [6:0] MAX_W7 = 7'(MAX_W);

  state_t state_q, state_d;

  logic [6:0] wr_col_q, rd_col_q, width_q;
  logic [2:0] wr_row_q, phase_q, dec_q;

  logic accept, line_end, frame_last, re, rd_last;
  logic [6:0] width_m1;
  logic [2:0] dec_m1;

  logic [NTAP-1:0]  ram_we;
  logic [PIX_W-1:0] ram_q [NTAP];
  logic [NTAP-1:0]  tap_en_q;
  logic [2:0]       sel_q [NTAP];
  logic [PIX_W-1:0] taps [NTAP];
  logic             last_q;

  assign width_m1   = width_q - 7'd1;
  assign dec_m1     = dec_q - 3'd1;
  assign in_ready   = (state_q == FILL);
  assign accept     = in_valid && in_ready && !sof && !rst;
  assign line_end   = accept && (wr_col_q == width_m1);
  assign frame_last = line_end && (phase_q == dec_m1);
  assign rd_last    = (rd_col_q == width_m1);
  assign re         = (state_q == READ) && !sof && !rst;
  assign dbg_state  = state_q;

  // State register; sof and rst both force FILL.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next state: enter READ on the last pixel of the D-th line, leave after the scan.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (frame_last) state_d = READ;
      READ: if (rd_last)    state_d = FILL;
      default: state_d = FILL;
    endcase
    if (sof) state_d = FILL;
  end

  // Configuration latch and write/read position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q  <= MAX_W7;
      dec_q    <= 3'd1;
      wr_col_q <= '0;
      wr_row_q <= '0;
      phase_q  <= '0;
      rd_col_q <= '0;
    end else if (sof) begin
      width_q  <= clamp_width(cfg_width, MAX_W7);
      dec_q    <= clamp_dec(cfg_dec);
      wr_col_q <= '0;
      wr_row_q <= '0;
      phase_q  <= '0;
      rd_col_q <= '0;
    end else begin
      if (accept) begin
        if (line_end) begin
          wr_col_q <= '0;
          wr_row_q <= (wr_row_q == 3'(NTAP - 1)) ? 3'd0 : wr_row_q + 3'd1;
          phase_q  <= (phase_q == dec_m1) ? 3'd0 : phase_q + 3'd1;
        end else begin
          wr_col_q <= wr_col_q + 7'd1;
        end
      end
      if (state_q == READ) rd_col_q <= rd_last ? 7'd0 : rd_col_q + 7'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NTAP; gi++) begin : g_row
      assign ram_we[gi] = accept && (wr_row_q == 3'(gi));
      line_ram #(.DEPTH(MAX_W), .AW(AW), .W(PIX_W)) u_ram (
        .clk   (clk),
        .we    (ram_we[gi]),
        .waddr (wr_col_q[AW-1:0]),
        .wdata (in_pix),
        .re    (re),
        .raddr (rd_col_q[AW-1:0]),
        .rdata (ram_q[gi])
      );
    end
  endgenerate

  // Strobe and tap routing, registered alongside the RAM read so they stay aligned
  // and hold once the scan ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_load  <= 1'b0;
      last_q   <= 1'b0;
      tap_en_q <= '0;
      for (int k = 0; k < NTAP; k++) sel_q[k] <= '0;
    end else begin
      en_load <= re;
      last_q  <= re && rd_last;
      if (re) begin
        for (int k = 0; k < NTAP; k++) begin
          tap_en_q[k] <= (3'(k + 1) <= dec_q);
          sel_q[k]    <= row_back(wr_row_q, 3'(k + 1));
        end
      end
    end
  end

  // Tap k shows the line k-1 rows older than the newest one, or 0 beyond D.
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      taps[k] = '0;
      if (tap_en_q[k]) taps[k] = ram_q[sel_q[k]];
    end
  end

  assign br1P = taps[0];
  assign br2P = taps[1];
  assign br3P = taps[2];
  assign br4P = taps[3];
  assign br5P = taps[4];

`ifdef LINE_FEEDER_Y_ROW_CNT_EN
  // Count emitted rows, bumping after the final strobe of each scan.
  always_ff @(posedge clk) begin
    if (rst || sof)                                out_row <= '0;
    else if (en_load && last_q && out_row != 8'hff) out_row <= out_row + 8'd1;
  end
`endif

endmodule

// File: tb/tb_line_feeder_y.sv
// Directed bench for line_feeder_y with an expected-column scoreboard.
module tb_line_feeder_y;

  logic       clk;
  logic       rst;
  logic       sof;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pix;
  logic [6:0] cfg_width;
  logic [2:0] cfg_dec;
  logic       en_load;
  logic [7:0] br1P, br2P, br3P, br4P, br5P;
  logic       dbg_state;
`ifdef LINE_FEEDER_Y_ROW_CNT_EN
  logic [7:0] out_row;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int load_cnt = 0;
  int ready_low = 0;

  logic [39:0] exp_q[$];
  logic [39:0] taps_now, taps_prev, mon_e;
  logic        prev_en;

  line_feeder_y #(.MAX_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .cfg_width (cfg_width),
    .cfg_dec   (cfg_dec),
    .en_load   (en_load),
    .br1P      (br1P),
    .br2P      (br2P),
    .br3P      (br3P),
    .br4P      (br4P),
    .br5P      (br5P),
`ifdef LINE_FEEDER_Y_ROW_CNT_EN
    .out_row   (out_row),
`endif
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  assign taps_now = {br1P, br2P, br3P, br4P, br5P};

  // Scoreboard: every strobe must match the next expected column.
  initial prev_en = 1'b0;
  always @(negedge clk) begin
    if (en_load) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_load", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("taps", {24'd0, taps_now}, {24'd0, mon_e});
      end
    end else if (prev_en && !rst) begin
      check_eq("hold", {24'd0, taps_now}, {24'd0, taps_prev});
    end
    if (!in_ready) ready_low++;
    prev_en   = en_load;
    taps_prev = taps_now;
  end

  task automatic push_exp(input int n, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    for (int i = 0; i < n; i++) exp_q.push_back({b1, b2, b3, b4, b5});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg_sof(input logic [6:0] w, input logic [2:0] d);
    cfg_width = w;
    cfg_dec   = d;
    sof       = 1'b1;
    @(posedge clk);
    #1 sof = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] v);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_pix   = v;
    while (!in_ready && g < 500) begin
      @(posedge clk);
      #1 g++;
    end
    if (!in_ready) check_eq("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input int base, input int w, input bit ramp, input bit keep);
    for (int c = 0; c < w; c++) send_pix(ramp ? 8'(base + c) : 8'(base));
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_loads(input int target);
    int g;
    g = 0;
    while (load_cnt < target && g < 500) begin
      @(negedge clk);
      #1 g++;
    end
    check_eq("load_count", load_cnt, target);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
  endtask

  // Five-row ramp burst: row r pixel c holds r*20+c, taps newest first.
  task automatic push_ramp_burst(input int newest);
    for (int c = 0; c < 64; c++)
      push_exp(1, 8'(newest * 20 + c), 8'((newest - 1) * 20 + c), 8'((newest - 2) * 20 + c),
               8'((newest - 3) * 20 + c), 8'((newest - 4) * 20 + c));
  endtask

  initial begin
    int base;
    rst = 1'b0; sof = 1'b0; in_valid = 1'b0; in_pix = '0;
    cfg_width = 7'd64; cfg_dec = 3'd1;
    do_reset();
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_en_load", en_load, 0);
    check_eq("rst_taps", {24'd0, taps_now}, 64'd0);
    check_eq("rst_state", dbg_state, 0);

    // D=1, width 4, constant rows
    cfg_sof(7'd4, 3'd1);
    send_row(10, 4, 0, 0);
    push_exp(4, 8'd10, 0, 0, 0, 0);
    wait_idle();
    send_row(20, 4, 0, 0);
    push_exp(4, 8'd20, 0, 0, 0, 0);
    wait_idle();

    // D=3, width 8, row r = r; bursts only after rows 2 and 5
    cfg_sof(7'd8, 3'd3);
    for (int r = 0; r < 6; r++) begin
      send_row(r, 8, 0, 0);
      if (r == 2) push_exp(8, 8'd2, 8'd1, 8'd0, 0, 0);
      if (r == 5) push_exp(8, 8'd5, 8'd4, 8'd3, 0, 0);
      if (r == 2 || r == 5) wait_idle();
    end

    // D=5, width 64, in_valid held high across the readout
    cfg_sof(7'd64, 3'd5);
    ready_low = 0;
    for (int r = 0; r < 10; r++) begin
      send_row(r * 20, 64, 1, 1);
      if (r == 4) push_ramp_burst(4);
      if (r == 5) check_eq("ready_low_64", ready_low, 64);
      if (r == 9) push_ramp_burst(9);
    end
    in_valid = 1'b0;
    wait_idle();
    check_eq("ready_low_128", ready_low, 128);

    // cfg_dec=7 acts as D=5, cfg_width=0 as full width
    cfg_sof(7'd0, 3'd7);
    for (int r = 0; r < 5; r++) send_row(r * 20, 64, 1, 0);
    push_ramp_burst(4);
    wait_idle();

    // cfg_dec=0 acts as D=1
    cfg_sof(7'd4, 3'd0);
    send_row(33, 4, 0, 0);
    push_exp(4, 8'd33, 0, 0, 0, 0);
    wait_idle();
    send_row(44, 4, 0, 0);
    push_exp(4, 8'd44, 0, 0, 0, 0);
    wait_idle();

    // sof on the 3rd strobe aborts the scan
    cfg_sof(7'd8, 3'd2);
    send_row(1, 8, 0, 0);
    send_row(2, 8, 0, 0);
    push_exp(3, 8'd2, 8'd1, 0, 0, 0);
    base = load_cnt;
    wait_loads(base + 3);
    cfg_sof(7'd8, 3'd2);
    @(negedge clk);
    check_eq("abort_en_load", en_load, 0);
    check_eq("abort_state", dbg_state, 0);
    check_eq("abort_in_ready", in_ready, 1);
    wait_idle();
    check_eq("abort_loads", load_cnt, base + 3);
    // mid-line sof must restart at column 0, phase 0
    send_row(7, 8, 0, 0);
    send_row(8, 3, 0, 0);
    cfg_sof(7'd8, 3'd2);
    send_row(50, 8, 0, 0);
    send_row(60, 8, 0, 0);
    push_exp(8, 8'd60, 8'd50, 0, 0, 0);
    wait_idle();

    // rst during a scan aborts it and restores default configuration
    cfg_sof(7'd8, 3'd1);
    send_row(9, 8, 0, 0);
    push_exp(2, 8'd9, 0, 0, 0, 0);
    base = load_cnt;
    wait_loads(base + 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_mid_en_load", en_load, 0);
    check_eq("rst_mid_taps", {24'd0, taps_now}, 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_in_ready", in_ready, 1);
    check_eq("rst_mid_state", dbg_state, 0);
    check_eq("rst_mid_loads", load_cnt, base + 2);
    send_row(3, 64, 0, 0);
    push_exp(64, 8'd3, 0, 0, 0, 0);
    wait_idle();

`ifdef LINE_FEEDER_Y_ROW_CNT_EN
    // row counter: D=2, 10 rows -> 5 bursts
    do_reset();
    cfg_sof(7'd4, 3'd2);
    for (int r = 0; r < 10; r++) begin
      send_row(r + 1, 4, 0, 0);
      if (r % 2 == 1) push_exp(4, 8'(r + 1), 8'(r), 0, 0, 0);
      if (r % 2 == 1) wait_idle();
    end
    check_eq("out_row_5", out_row, 5);
    do_reset();
    @(negedge clk);
    check_eq("out_row_rst", out_row, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/line_feeder_y.md
LINE_FEEDER_Y -- requirements
Module: line_feeder_y

Interface
REQ-001 SHALL have parameter MAX_W, default 64, giving the maximum line width in pixels.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port sof, input, 1 bit: start-of-frame pulse, which samples the configuration.
REQ-005 SHALL have port in_valid, input, 1 bit: the input pixel is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a pixel; a transfer occurs when in_valid and in_ready are both high.
REQ-007 SHALL have port in_pix, input, 8 bits: horizontally filtered pixel, raster order.
REQ-008 SHALL have port cfg_width, input, 7 bits: line width (1..MAX_W).
REQ-009 SHALL have port cfg_dec, input, 3 bits: vertical decimation factor D (1..5).
REQ-010 SHALL have port en_load, output, 1 bit: one-cycle strobe marking a valid output column.
REQ-011 SHALL have ports br1P..br5P, output, 8 bits each: the vertical tap column; br1P is the newest row, brkP is row r-(k-1).

Function
REQ-012 SHALL latch cfg_width and cfg_dec on sof.
- cfg_dec of 0 SHALL be treated as 1; values above 5 SHALL be clamped to 5.
- cfg_width of 0 or above MAX_W SHALL be clamped to MAX_W.
REQ-013 SHALL store lines in 5 circular row buffers; an accepted pixel is written at (wr_row, wr_col).
REQ-014 On each accepted pixel, wr_col SHALL increment; at cfg_width-1 it SHALL wrap to 0, advance wr_row modulo 5, and advance phase modulo D.
REQ-015 The FSM SHALL have two states, FILL and READ; reset state is FILL.
REQ-016 FILL SHALL move to READ on the cycle that the last pixel of a line is accepted with phase == D-1; otherwise it SHALL stay in FILL.
REQ-017 READ SHALL scan rd_col from 0 to cfg_width-1, one column per cycle, then return to FILL.
REQ-018 in_ready SHALL be 1 in FILL and 0 in READ; in_valid in READ SHALL be ignored and no write SHALL occur.
REQ-019 Row buffers SHALL be read synchronously, so en_load and br*P are registered and aligned, asserted one cycle after each rd_col is issued.
- Output is exactly cfg_width consecutive en_load pulses per emitted row.
REQ-020 Taps k > D SHALL output 0 on br(k)P during en_load.
REQ-021 br*P SHALL hold their last value when en_load is 0.
REQ-022 Output rows SHALL use the D most recently completed lines: br1P = the line just completed, br(k)P = k-1 lines earlier.
REQ-023 sof SHALL take priority over all other events:
- clear wr_col, wr_row and phase;
- force FILL;
- abort any readout, with en_load 0 from the next cycle onward;
- no pixel accepted in the sof cycle SHALL be written.
REQ-024 Buffer contents SHALL NOT be cleared by sof or rst.

Reset
REQ-025 rst SHALL, on the clock edge, return the FSM to FILL and clear wr_col, wr_row, phase, rd_col and the latched configuration (D=1, width=MAX_W).
REQ-026 Reset values of outputs: in_ready=1 the cycle after reset, en_load=0, br1P..br5P=0.
REQ-027 rst asserted during READ SHALL abort readout immediately, with the same behaviour as REQ-025 and REQ-026.

Configuration
REQ-028 Macro LINE_FEEDER_Y_ROW_CNT_EN, when defined, SHALL add output port out_row, 8 bits:
- cleared by rst and sof;
- incremented on the cycle after the last en_load of each emitted row, saturating at 255.
REQ-029 Without LINE_FEEDER_Y_ROW_CNT_EN, port out_row and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package line_feeder_y_pkg SHALL hold:
- NTAP=5;
- MAX_DEC=5;
- the FSM state enum (FILL, READ);
- the pixel width constant 8.
REQ-031 Sub-module line_ram SHALL be a 1-write/1-read synchronous RAM of MAX_W x 8, instantiated NTAP times.

Verification
REQ-032 Test D=1, width=4, rows of constant value 10,20: after each row, 4 en_load pulses with br1P=10 then br1P=20, and br2P..br5P=0.
REQ-033 Test D=3, width=8, row r filled with value r (r=0..5): en_load bursts only after rows 2 and 5, with (br1P,br2P,br3P)=(2,1,0) and then (5,4,3).
REQ-034 Test D=5, width=64, in_valid held high: in_ready low for exactly 64 cycles after row 4; no pixel is lost or duplicated.
REQ-035 Test sof pulsed at the 3rd en_load of a readout: en_load is 0 from the next cycle; the next frame starts at column 0, phase 0.
REQ-036 Test cfg_dec=7 and cfg_dec=0: behaviour matches D=5 and D=1 respectively.
REQ-037 Test with LINE_FEEDER_Y_ROW_CNT_EN defined, D=2, 10 rows: out_row=5 after the last burst; rst then returns out_row to 0.
